control_loop_sequencer: RTL and testbench

Periodic scheduler for the wall-follower control loop. It generates a fixed-rate sample tick and sequences each loop iteration in order: sensor acquisition, then PID compute, then actuator update. Each stage is a start-pulse/done handshake. The block sits between the distance-sensor front end, the PID core and the motor PWM register stage. It flags timeouts and overruns and counts completed loops.

---
 rtl/control_loop_sequencer.sv | 106 ++++++++++
 tb/tb_control_loop_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/control_loop_sequencer.sv
// Fixed-rate loop scheduler: period tick, then SENSE -> COMPUTE -> UPDATE handshakes.
// Optional `define PID_TIMEOUT_EN bounds the COMPUTE stage by PID_TIMEOUT_CYCLES.
module control_loop_sequencer #(
  parameter int unsigned PERIOD_CYCLES        = 1000000,
  parameter int unsigned SENSE_TIMEOUT_CYCLES = 1250000,
  parameter int unsigned PID_TIMEOUT_CYCLES   = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        sense_start,
  input  logic        sense_done,
  output logic        pid_start,
  input  logic        pid_done,
  output logic        drive_update,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun,
  input  logic        clr_err,
  output logic [15:0] loop_count
);

  typedef enum logic [1:0] {IDLE, SENSE, COMPUTE, UPDATE} state_t;

  state_t      state;
  logic [31:0] per_cnt;
  logic [31:0] stg_cnt;
  logic        tick, sense_ok, sense_to, pid_ok, pid_to;

  assign tick     = en && (per_cnt == 32'(PERIOD_CYCLES - 1));
  // done is ignored in the start-pulse cycle (stage count 0) so a held level can't skip a stage
  assign sense_ok = (state == SENSE) && (stg_cnt != 32'd0) && sense_done;
  assign sense_to = (state == SENSE) && !sense_ok && (stg_cnt == 32'(SENSE_TIMEOUT_CYCLES - 1));
  assign pid_ok   = (state == COMPUTE) && (stg_cnt != 32'd0) && pid_done;
`ifdef PID_TIMEOUT_EN
  assign pid_to   = (state == COMPUTE) && !pid_ok && (stg_cnt == 32'(PID_TIMEOUT_CYCLES - 1));
`else
  // COMPUTE never times out in this build; the parameter only appears here
  assign pid_to   = (PID_TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                per_cnt <= '0;
    else if (!en || tick)   per_cnt <= '0;
    else                    per_cnt <= per_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      stg_cnt      <= '0;
      sense_start  <= 1'b0;
      pid_start    <= 1'b0;
      drive_update <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
      loop_count   <= '0;
    end else begin
      sense_start  <= 1'b0;
      pid_start    <= 1'b0;
      drive_update <= 1'b0;
      timeout_err  <= (timeout_err & ~clr_err) | sense_to | pid_to;
      overrun      <= (overrun & ~clr_err) | (tick && state != IDLE);
      if (stg_cnt != '1) stg_cnt <= stg_cnt + 32'd1;
      if (!en) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (tick) begin
            state       <= SENSE;
            sense_start <= 1'b1;
            stg_cnt     <= '0;
            busy        <= 1'b1;
          end
          SENSE: begin
            if (sense_ok) begin
              state     <= COMPUTE;
              pid_start <= 1'b1;
              stg_cnt   <= '0;
            end else if (sense_to) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          COMPUTE: begin
            if (pid_ok) begin
              state        <= UPDATE;
              drive_update <= 1'b1;
              loop_count   <= loop_count + 16'd1;
            end else if (pid_to) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_loop_sequencer.sv
// Directed bench: pulse scoreboard on the main instance, overrun scenario on a second instance.
module tb_control_loop_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, en, sense_done, pid_done, clr_err;
  logic sense_start, pid_start, drive_update, busy, timeout_err, overrun;
  logic [15:0] loop_count;

  logic rst_o, en_o, clr_o;
  logic sense_start_o, pid_start_o, drive_update_o, busy_o, timeout_o, overrun_o;
  logic [15:0] loop_count_o;

  control_loop_sequencer #(.PERIOD_CYCLES(100), .SENSE_TIMEOUT_CYCLES(20), .PID_TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .en(en), .sense_start(sense_start), .sense_done(sense_done),
    .pid_start(pid_start), .pid_done(pid_done), .drive_update(drive_update), .busy(busy),
    .timeout_err(timeout_err), .overrun(overrun), .clr_err(clr_err), .loop_count(loop_count));

  control_loop_sequencer #(.PERIOD_CYCLES(100), .SENSE_TIMEOUT_CYCLES(150), .PID_TIMEOUT_CYCLES(10)) dut_o (
    .clk(clk), .rst(rst_o), .en(en_o), .sense_start(sense_start_o), .sense_done(1'b0),
    .pid_start(pid_start_o), .pid_done(1'b0), .drive_update(drive_update_o), .busy(busy_o),
    .timeout_err(timeout_o), .overrun(overrun_o), .clr_err(clr_o), .loop_count(loop_count_o));

  typedef struct { logic [2:0] kind; int at_cyc; logic [15:0] lc; } ev_t;
  localparam logic [2:0] K_S = 3'b001, K_P = 3'b010, K_U = 3'b100;
  ev_t sb[$];
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input int c, input logic [15:0] lc);
    ev_t e;
    e.kind = k; e.at_cyc = c; e.lc = lc;
    sb.push_back(e);
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every start/update pulse must match the next expected event
  always @(negedge clk) begin
    if (!rst && (sense_start || pid_start || drive_update)) begin
      ev_t e;
      logic [2:0] k;
      k = {drive_update, pid_start, sense_start};
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, k}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {29'd0, k}, {29'd0, e.kind});
        check("pulse_cycle", cyc, e.at_cyc);
        if (k == K_U) check("loop_count_at_update", {16'd0, loop_count}, {16'd0, e.lc});
      end
    end
  end

  int c0, c1, d0;

  initial begin
    rst = 1'b1; en = 1'b0; sense_done = 1'b0; pid_done = 1'b0; clr_err = 1'b0;
    rst_o = 1'b1; en_o = 1'b0; clr_o = 1'b0;
    at(2);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_pulses", {29'd0, drive_update, pid_start, sense_start}, 0);
    check("rst_flags", {30'd0, timeout_err, overrun}, 0);
    check("rst_loop_count", {16'd0, loop_count}, 0);
    at(3); rst = 1'b0; rst_o = 1'b0;

    // Nominal loop
    c0 = 5; at(c0); en = 1'b1;
    push(K_S, c0+100, 0); push(K_P, c0+106, 0); push(K_U, c0+110, 16'd1);
    at(c0+99); check("idle_before_tick", {31'd0, busy}, 0);
    at(c0+105); check("busy_in_sense", {31'd0, busy}, 1);
    sense_done = 1'b1; @(negedge clk); sense_done = 1'b0;
    at(c0+109); pid_done = 1'b1; @(negedge clk); pid_done = 1'b0;
    at(c0+111); check("busy_low_after_update", {31'd0, busy}, 0);
    check("loop_count_1", {16'd0, loop_count}, 1);

    // Held-level dones: pid_start two cycles after sense_start
    at(c0+150); sense_done = 1'b1; pid_done = 1'b1;
    push(K_S, c0+200, 0); push(K_P, c0+202, 0); push(K_U, c0+204, 16'd2);
    at(c0+205); check("busy_low_level_loop", {31'd0, busy}, 0);
    at(c0+250); sense_done = 1'b0; pid_done = 1'b0;

    // Sense timeout
    push(K_S, c0+300, 0);
    at(c0+319); check("no_timeout_yet", {31'd0, timeout_err}, 0);
    at(c0+320); check("sense_timeout", {31'd0, timeout_err}, 1);
    check("idle_after_timeout", {31'd0, busy}, 0);
    check("loop_count_kept", {16'd0, loop_count}, 2);
    at(c0+350); clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("clr_timeout", {31'd0, timeout_err}, 0);

    // Drop en during COMPUTE
    push(K_S, c0+400, 0); push(K_P, c0+403, 0);
    at(c0+402); sense_done = 1'b1; @(negedge clk); sense_done = 1'b0;
    at(c0+405); en = 1'b0;
    at(c0+406); check("abort_idle", {31'd0, busy}, 0);
    check("abort_loop_count", {16'd0, loop_count}, 2);
    at(c0+420); check("abort_no_timeout", {31'd0, timeout_err}, 0);

    // Reset during SENSE
    c1 = c0 + 430; at(c1); en = 1'b1;
    push(K_S, c1+100, 0);
    at(c1+103); check("busy_before_rst", {31'd0, busy}, 1);
    rst = 1'b1; #1;
    check("rst_async_busy", {31'd0, busy}, 0);
    check("rst_async_loop_count", {16'd0, loop_count}, 0);
    at(c1+104); rst = 1'b0;

    // loop_count wrap
    at(c1+110); force dut.loop_count = 16'hFFFF; @(negedge clk); release dut.loop_count;
    push(K_S, c1+204, 0); push(K_P, c1+207, 0); push(K_U, c1+210, 16'd0);
    at(c1+206); sense_done = 1'b1; @(negedge clk); sense_done = 1'b0;
    at(c1+209); pid_done = 1'b1; @(negedge clk); pid_done = 1'b0;
    at(c1+211); check("wrap_loop_count", {16'd0, loop_count}, 0);

    // Hung COMPUTE
    push(K_S, c1+304, 0); push(K_P, c1+307, 0);
    at(c1+306); sense_done = 1'b1; @(negedge clk); sense_done = 1'b0;
    at(c1+316); check("pid_no_timeout_yet", {31'd0, timeout_err}, 0);
`ifdef PID_TIMEOUT_EN
    at(c1+317); check("pid_timeout", {31'd0, timeout_err}, 1);
    check("pid_timeout_idle", {31'd0, busy}, 0);
    at(c1+380); check("pid_timeout_stays_idle", {31'd0, busy}, 0);
`else
    at(c1+317); check("pid_hang_busy", {31'd0, busy}, 1);
    check("pid_hang_no_timeout", {31'd0, timeout_err}, 0);
    at(c1+380); check("pid_hang_still_busy", {31'd0, busy}, 1);
`endif
    at(c1+390); en = 1'b0;
    at(c1+400); check("final_idle", {31'd0, busy}, 0);

    // Overrun on second instance
    d0 = c1 + 410; at(d0); en_o = 1'b1;
    at(d0+100); check("o_sense_start", {31'd0, sense_start_o}, 1);
    at(d0+199); check("o_no_overrun_yet", {31'd0, overrun_o}, 0);
    at(d0+200); check("o_overrun", {31'd0, overrun_o}, 1);
    check("o_no_restart", {31'd0, sense_start_o}, 0);
    check("o_still_busy", {31'd0, busy_o}, 1);
    at(d0+250); check("o_timeout", {31'd0, timeout_o}, 1);
    check("o_idle", {31'd0, busy_o}, 0);
    check("o_no_pid_or_update", {15'd0, pid_start_o, drive_update_o, loop_count_o}, 0);
    at(d0+260); clr_o = 1'b1; @(negedge clk); clr_o = 1'b0;
    check("o_clr_overrun", {31'd0, overrun_o}, 0);
    check("o_clr_timeout", {31'd0, timeout_o}, 0);
    at(d0+300); check("o_next_sense_start", {31'd0, sense_start_o}, 1);
    at(d0+399); clr_o = 1'b1; @(negedge clk); clr_o = 1'b0;
    check("o_set_beats_clr", {31'd0, overrun_o}, 1);
    en_o = 1'b0;

    at(d0+410);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
